// File: rtl/lcd_seq_pkg.sv
// lcd_seq_pkg: state encodings, default panel timing and rail decode for lcd_power_sequencer
package lcd_seq_pkg;
  typedef enum logic [2:0] {
    S_OFF     = 3'd0,
    S_VDD_UP  = 3'd1,
    S_LVDS_UP = 3'd2,
    S_ON      = 3'd3,
    S_BL_DN   = 3'd4,
    S_LVDS_DN = 3'd5
  } seqStateT;
  localparam int DEF_CLOCK_KHZ        = 25000;
  localparam int DEF_T_VDD_LVDS_MS    = 10;
  localparam int DEF_T_LVDS_BL_MS     = 200;
  localparam int DEF_T_BL_LVDS_MS     = 200;
  localparam int DEF_T_LVDS_VDD_MS    = 10;
  localparam int DEF_T_OFF_MIN_MS     = 500;
  localparam int DEF_VSYNC_TIMEOUT_MS = 100;
  function automatic logic [2:0] railsOf(seqStateT s);
    return s == S_VDD_UP  ? 3'b100 :
           s == S_LVDS_UP ? 3'b110 :
           s == S_ON      ? 3'b111 :
           s == S_BL_DN   ? 3'b110 :
           s == S_LVDS_DN ? 3'b100 : 3'b000;
  endfunction
endpackage

// File: rtl/seq_ms_timer.sv
// seq_ms_timer: millisecond dwell timer (prescaler + ms down-counter)
//  sysClock/sysReset: clock, sync active-high reset (reset leaves the timer expired)
//  load/loadValue: restart with loadValue ms; done: high in the last cycle of the dwell and after
module seq_ms_timer #(
  parameter int CLOCK_KHZ = 25000
) (
  input  logic        sysClock,
  input  logic        sysReset,
  input  logic        load,
  input  logic [15:0] loadValue,
  output logic        done
);
  localparam int PW = CLOCK_KHZ > 1 ? $clog2(CLOCK_KHZ) : 1;
  logic [PW-1:0] preCnt;
  logic [15:0]   msCnt;
  always_ff @(posedge sysClock) begin
    if (sysReset) begin
      preCnt <= '0;
      msCnt  <= '0;
    end else if (load) begin
      preCnt <= PW'(CLOCK_KHZ - 1);
      msCnt  <= loadValue;
    end else if (preCnt == '0) begin
      preCnt <= PW'(CLOCK_KHZ - 1);
      msCnt  <= msCnt == '0 ? '0 : msCnt - 16'd1;
    end else begin
      preCnt <= preCnt - 1'b1;
    end
  end
  // done one cycle early so a transition taken on it lands exactly T*CLOCK_KHZ cycles after load
  assign done = (msCnt == '0) | (msCnt == 16'd1 & preCnt == '0);
endmodule

// File: rtl/lcd_power_sequencer.sv
// lcd_power_sequencer: panel VDD / LVDS / backlight power sequencer with vsync watchdog
//  sysClock, sysReset (sync, active-high); panelOnReq level request; vsync async LTDC vsync;
//  brightness backlight duty; panelVdd, lvdsEnable, blEnable rails; blPwm backlight PWM;
//  panelReady high in S_ON; videoFault sticky watchdog trip; seqState current state.
//  Define BACKLIGHT_PWM_EN to generate blPwm from brightness; otherwise blPwm = blEnable.
module lcd_power_sequencer import lcd_seq_pkg::*; #(
  parameter int CLOCK_KHZ        = DEF_CLOCK_KHZ,
  parameter int T_VDD_LVDS_MS    = DEF_T_VDD_LVDS_MS,
  parameter int T_LVDS_BL_MS     = DEF_T_LVDS_BL_MS,
  parameter int T_BL_LVDS_MS     = DEF_T_BL_LVDS_MS,
  parameter int T_LVDS_VDD_MS    = DEF_T_LVDS_VDD_MS,
  parameter int T_OFF_MIN_MS     = DEF_T_OFF_MIN_MS,
  parameter int VSYNC_TIMEOUT_MS = DEF_VSYNC_TIMEOUT_MS
) (
  input  logic       sysClock,
  input  logic       sysReset,
  input  logic       panelOnReq,
  input  logic       vsync,
  input  logic [7:0] brightness,
  output logic       panelVdd,
  output logic       lvdsEnable,
  output logic       blEnable,
  output logic       blPwm,
  output logic       panelReady,
  output logic       videoFault,
  output logic [2:0] seqState
);
  seqStateT    state, nextState;
  logic        seqDone, wdDone, vsyncRise, trip, powerOk, reqLowSeen;
  logic [2:0]  vsyncSync;
  logic [15:0] dwell;
  // [0],[1] synchroniser flops, [2] previous synchronised value for edge detect
  assign vsyncRise = vsyncSync[1] & ~vsyncSync[2];
  assign trip      = (state == S_ON) & wdDone & ~vsyncRise;
  assign powerOk   = ~videoFault | reqLowSeen;
  assign seqState  = state;
  always_comb begin
    nextState = state;
    case (state)
      S_OFF:     nextState = panelOnReq & seqDone & powerOk ? S_VDD_UP : S_OFF;
      S_VDD_UP:  nextState = ~panelOnReq ? S_OFF : seqDone ? S_LVDS_UP : S_VDD_UP;
      S_LVDS_UP: nextState = ~panelOnReq ? S_LVDS_DN : seqDone ? S_ON : S_LVDS_UP;
      S_ON:      nextState = ~panelOnReq | trip ? S_BL_DN : S_ON;
      S_BL_DN:   nextState = seqDone ? S_LVDS_DN : S_BL_DN;
      S_LVDS_DN: nextState = seqDone ? S_OFF : S_LVDS_DN;
      default:   nextState = S_LVDS_DN;
    endcase
    dwell = nextState == S_OFF     ? 16'(T_OFF_MIN_MS)  :
            nextState == S_VDD_UP  ? 16'(T_VDD_LVDS_MS) :
            nextState == S_LVDS_UP ? 16'(T_LVDS_BL_MS)  :
            nextState == S_BL_DN   ? 16'(T_BL_LVDS_MS)  :
            nextState == S_LVDS_DN ? 16'(T_LVDS_VDD_MS) : 16'd0;
  end
  always_ff @(posedge sysClock) begin
    if (sysReset) begin
      state                            <= S_OFF;
      {panelVdd, lvdsEnable, blEnable} <= 3'b000;
      panelReady                       <= 1'b0;
      videoFault                       <= 1'b0;
      reqLowSeen                       <= 1'b0;
      vsyncSync                        <= 3'b000;
    end else begin
      state                            <= nextState;
      {panelVdd, lvdsEnable, blEnable} <= railsOf(nextState);
      panelReady                       <= nextState == S_ON;
      videoFault                       <= trip | (videoFault & ~(state == S_OFF & nextState == S_VDD_UP));
      reqLowSeen                       <= trip ? ~panelOnReq : reqLowSeen | ~panelOnReq;
      vsyncSync                        <= {vsyncSync[1:0], vsync};
    end
  end
  seq_ms_timer #(.CLOCK_KHZ(CLOCK_KHZ)) seqTimer (
    .sysClock  (sysClock),
    .sysReset  (sysReset),
    .load      (nextState != state),
    .loadValue (dwell),
    .done      (seqDone)
  );
  // held in load outside S_ON so it starts fresh on S_ON entry
  seq_ms_timer #(.CLOCK_KHZ(CLOCK_KHZ)) wdTimer (
    .sysClock  (sysClock),
    .sysReset  (sysReset),
    .load      ((state != S_ON) | vsyncRise),
    .loadValue (16'(VSYNC_TIMEOUT_MS)),
    .done      (wdDone)
  );
`ifdef BACKLIGHT_PWM_EN
  localparam int PWM_DIV = CLOCK_KHZ / 256 < 1 ? 1 : CLOCK_KHZ / 256;
  localparam int PPW     = PWM_DIV > 1 ? $clog2(PWM_DIV) : 1;
  logic [PPW-1:0] pwmPre;
  logic [7:0]     pwmCnt, duty;
  logic           pwmStep;
  assign pwmStep = pwmPre == PPW'(PWM_DIV - 1);
  always_ff @(posedge sysClock) begin
    if (sysReset) begin
      pwmPre <= '0;
      pwmCnt <= '0;
      duty   <= '0;
    end else begin
      pwmPre <= pwmStep ? '0 : pwmPre + 1'b1;
      pwmCnt <= pwmStep ? pwmCnt + 8'd1 : pwmCnt;
      duty   <= pwmStep & pwmCnt == 8'hff ? brightness : duty;
    end
  end
  assign blPwm = blEnable & (pwmCnt < duty);
`else
  logic unusedBrightness;
  assign unusedBrightness = ^brightness;
  assign blPwm = blEnable;
`endif
endmodule

// File: tb/tb_lcd_power_sequencer.sv
// tb_lcd_power_sequencer: directed self-checking bench for lcd_power_sequencer
module tb_lcd_power_sequencer;
`ifdef BACKLIGHT_PWM_EN
  localparam bit PWM_ON = 1'b1;
`else
  localparam bit PWM_ON = 1'b0;
`endif
  logic       sysClock = 1'b0;
  logic       sysReset, panelOnReq, vsync;
  logic [7:0] brightness;
  logic       panelVdd, lvdsEnable, blEnable, blPwm, panelReady, videoFault;
  logic [2:0] seqState;
  int         cyc, checks, errors, hi, lastRise;
  logic       vsyncRun, lvdsSeen;
  lcd_power_sequencer #(
    .CLOCK_KHZ(4), .T_VDD_LVDS_MS(2), .T_LVDS_BL_MS(3), .T_BL_LVDS_MS(3),
    .T_LVDS_VDD_MS(2), .T_OFF_MIN_MS(5), .VSYNC_TIMEOUT_MS(4)
  ) dut (
    .sysClock(sysClock), .sysReset(sysReset), .panelOnReq(panelOnReq), .vsync(vsync),
    .brightness(brightness), .panelVdd(panelVdd), .lvdsEnable(lvdsEnable), .blEnable(blEnable),
    .blPwm(blPwm), .panelReady(panelReady), .videoFault(videoFault), .seqState(seqState)
  );
  always #5 sysClock = ~sysClock;
  task automatic step();
    @(posedge sysClock);
    #1;
    cyc++;
    if (vsyncRun) vsync = (cyc % 10) < 5;
  endtask
  task automatic stepN(input int n);
    for (int i = 0; i < n; i++) step();
  endtask
  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic waitReady();
    for (int k = 0; k < 200 && !panelReady; k++) step();
    check("reach_on", 16'(panelReady), 16'd1);
  endtask
  task automatic countPwm();
    hi = 0;
    for (int i = 0; i < 256; i++) begin
      step();
      hi += int'(blPwm);
    end
  endtask
  initial begin
    cyc = 0; checks = 0; errors = 0; vsyncRun = 1'b0; lvdsSeen = 1'b0;
    sysReset = 1'b1; panelOnReq = 1'b0; vsync = 1'b0; brightness = 8'd0;
    stepN(3);
    check("rst_rails", 16'({panelVdd, lvdsEnable, blEnable, blPwm}), 16'd0);
    check("rst_state", 16'(seqState), 16'd0);
    check("rst_ready_fault", 16'({panelReady, videoFault}), 16'd0);
    sysReset = 1'b0; panelOnReq = 1'b1; vsyncRun = 1'b1;
    step();
    check("up_vdd@1", 16'(panelVdd), 16'd1);
    check("up_state@1", 16'(seqState), 16'd1);
    stepN(7);
    check("up_lvds@8", 16'(lvdsEnable), 16'd0);
    step();
    check("up_lvds@9", 16'({panelVdd, lvdsEnable, blEnable}), 16'b110);
    check("up_state@9", 16'(seqState), 16'd2);
    stepN(11);
    check("up_bl@20", 16'({blEnable, panelReady}), 16'd0);
    step();
    check("up_bl@21", 16'({blEnable, panelReady}), 16'b11);
    check("up_state@21", 16'(seqState), 16'd3);
    stepN(40);
    check("on_hold_state", 16'(seqState), 16'd3);
    check("on_hold_fault", 16'(videoFault), 16'd0);
    panelOnReq = 1'b0;
    step();
    check("dn_bl@N+1", 16'({panelVdd, lvdsEnable, blEnable, panelReady}), 16'b1100);
    check("dn_state@N+1", 16'(seqState), 16'd4);
    stepN(11);
    check("dn_lvds@N+12", 16'(lvdsEnable), 16'd1);
    step();
    check("dn_lvds@N+13", 16'({panelVdd, lvdsEnable}), 16'b10);
    check("dn_state@N+13", 16'(seqState), 16'd5);
    stepN(7);
    check("dn_vdd@N+20", 16'(panelVdd), 16'd1);
    step();
    check("dn_vdd@N+21", 16'(panelVdd), 16'd0);
    check("dn_state@N+21", 16'(seqState), 16'd0);
    panelOnReq = 1'b1;
    stepN(19);
    check("offmin_vdd@19", 16'(panelVdd), 16'd0);
    step();
    check("offmin_vdd@20", 16'(panelVdd), 16'd1);
    stepN(5);
    panelOnReq = 1'b0;
    step();
    check("abort_vdd", 16'(panelVdd), 16'd0);
    check("abort_state", 16'(seqState), 16'd0);
    for (int i = 0; i < 12; i++) begin
      step();
      lvdsSeen |= lvdsEnable;
    end
    check("abort_no_lvds", 16'(lvdsSeen), 16'd0);
    panelOnReq = 1'b1;
    waitReady();
    do step(); while (cyc % 10 != 0);
    // vsync just rose; hold it high so no further edges arrive
    vsyncRun = 1'b0;
    lastRise = cyc;
    stepN(18);
    check("wd_hold_fault", 16'(videoFault), 16'd0);
    check("wd_hold_state", 16'(seqState), 16'd3);
    step();
    check("wd_trip_fault", 16'(videoFault), 16'd1);
    check("wd_trip_state", 16'(seqState), 16'd4);
    check("wd_trip_bl", 16'({blEnable, panelReady}), 16'd0);
    check("wd_trip_time", 16'(cyc - lastRise), 16'd19);
    stepN(11);
    check("wd_lvds_hold", 16'(lvdsEnable), 16'd1);
    step();
    check("wd_lvds_off", 16'(lvdsEnable), 16'd0);
    stepN(7);
    check("wd_vdd_hold", 16'(panelVdd), 16'd1);
    step();
    check("wd_vdd_off", 16'(panelVdd), 16'd0);
    stepN(30);
    check("wd_block_state", 16'(seqState), 16'd0);
    check("wd_block_fault", 16'({videoFault, panelVdd}), 16'b10);
    panelOnReq = 1'b0;
    step();
    panelOnReq = 1'b1; vsyncRun = 1'b1;
    step();
    check("wd_repower_vdd", 16'(panelVdd), 16'd1);
    check("wd_repower_fault", 16'(videoFault), 16'd0);
    waitReady();
    brightness = 8'd64;
    stepN(600);
    countPwm();
    check("pwm_64", 16'(hi), PWM_ON ? 16'd64 : 16'd256);
    brightness = 8'd0;
    stepN(600);
    countPwm();
    check("pwm_0", 16'(hi), PWM_ON ? 16'd0 : 16'd256);
    brightness = 8'd255;
    stepN(600);
    countPwm();
    check("pwm_255", 16'(hi), PWM_ON ? 16'd255 : 16'd256);
    check("pwm_still_on", 16'(seqState), 16'd3);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
